// File: rtl/stack_flit_receiver_pkg.sv
// Purpose: shared diagnosis configuration for the stack-argument snapshot
//          flit stream: flit type codes, header bit layout, stack-args
//          maximum, receiver FSM state encoding and a header pack helper.
// Ports:   none (package).
package stack_flit_receiver_pkg;

    localparam int unsigned DIAG_STACK_ARGS_MAX = 16;

    localparam int unsigned FLIT_W    = 32;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned TYPE_W    = 3;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned ERR_CNT_W = 8;

    localparam logic [TYPE_W-1:0] SNAPSHOT_FLIT_TYPE_NONE   = 3'd0;
    localparam logic [TYPE_W-1:0] SNAPSHOT_FLIT_TYPE_FIRST  = 3'd1;
    localparam logic [TYPE_W-1:0] SNAPSHOT_FLIT_TYPE_MIDDLE = 3'd2;
    localparam logic [TYPE_W-1:0] SNAPSHOT_FLIT_TYPE_LAST   = 3'd3;
    localparam logic [TYPE_W-1:0] SNAPSHOT_FLIT_TYPE_SINGLE = 3'd4;

    localparam int unsigned HDR_ERR_BIT = 15;
    localparam int unsigned HDR_OVF_BIT = 14;
    localparam int unsigned HDR_CNT_MSB = 5;
    localparam int unsigned HDR_CNT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_HDR     = 3'd2,
        ST_EMIT_HI = 3'd3,
        ST_EMIT_LO = 3'd4
    } rx_state_e;

    // Header word: {err, ovf, 8'b0, cnt}
    function automatic logic [OUT_W-1:0] pack_hdr(
        input logic             err,
        input logic             ovf,
        input logic [CNT_W-1:0] cnt
    );
        logic [OUT_W-1:0] h;
        h                          = '0;
        h[HDR_ERR_BIT]             = err;
        h[HDR_OVF_BIT]             = ovf;
        h[HDR_CNT_MSB:HDR_CNT_LSB] = cnt;
        return h;
    endfunction

endpackage

// File: rtl/stack_flit_receiver_arg_buf.sv
// Purpose: argument buffer of one snapshot; one synchronous write port and
//          one asynchronous read port. Contents are not reset.
// Ports:   i_clk        clock
//          i_wr_en      write strobe
//          i_wr_addr    write index
//          i_wr_data    argument word to store
//          i_rd_addr    read index
//          o_rd_data_c  combinational read data
module stack_arg_buf
    import stack_flit_receiver_pkg::*;
#(
    parameter int unsigned DEPTH = DIAG_STACK_ARGS_MAX,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = FLIT_W
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data_c
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port
    assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/stack_flit_receiver.sv
// Purpose: consumer of the stack-argument snapshot flit stream. Checks
//          FIRST/MIDDLE/LAST/SINGLE/NONE framing, buffers one snapshot and
//          replays it as a header word plus 16-bit argument halves.
// Ports:   i_clk, i_rst_n   clock, synchronous active-low reset
//          i_in_data        32-bit argument word
//          i_in_type        flit type, sampled on a transfer only
//          i_in_valid       producer has a flit
//          o_in_rdy         receiver accepts (registered, state-only)
//          o_out_data       16-bit debug word
//          o_out_last       final word of a packet
//          o_out_valid      word available
//          i_out_ready      downstream accepts
//          o_err_cnt        saturating framing-error count
module stack_flit_receiver
    import stack_flit_receiver_pkg::*;
#(
    // Legal range 1..63; must match the diagnosis stack-args maximum.
    parameter int unsigned MAX_ARGS = DIAG_STACK_ARGS_MAX
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [FLIT_W-1:0]    i_in_data,
    input  logic [TYPE_W-1:0]    i_in_type,
    input  logic                 i_in_valid,
    output logic                 o_in_rdy,
    output logic [OUT_W-1:0]     o_out_data,
    output logic                 o_out_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int unsigned AW = (MAX_ARGS > 32'd1) ? 32'($clog2(MAX_ARGS)) : 32'd1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ARGS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    rx_state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]       r_idx, w_idx_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_ovf, w_ovf_nxt;
    logic                   w_err_inc;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_wr_en;
    logic [AW-1:0]          w_wr_addr;
    logic [AW-1:0]          w_rd_addr;
    logic [FLIT_W-1:0]      w_rd_data;

    logic                   r_in_rdy, w_in_rdy_nxt;
    logic                   r_out_valid, w_out_valid_nxt;
    logic                   r_out_last, w_out_last_nxt;
    logic [OUT_W-1:0]       r_out_data, w_out_data_nxt;

    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_last_arg;

    assign w_in_xfer  = i_in_valid && r_in_rdy;
    assign w_out_xfer = r_out_valid && i_out_ready;
    assign w_last_arg = (r_idx == (r_cnt - ONE_CNT));

    stack_arg_buf #(
        .DEPTH (MAX_ARGS),
        .AW    (AW),
        .DW    (FLIT_W)
    ) u_arg_buf (
        .i_clk       (i_clk),
        .i_wr_en     (w_wr_en),
        .i_wr_addr   (w_wr_addr),
        .i_wr_data   (i_in_data),
        .i_rd_addr   (w_rd_addr),
        .o_rd_data_c (w_rd_data)
    );

    // Next-state, counters, framing checks and buffer writes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        w_ovf_nxt   = r_ovf;
        w_err_inc   = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_addr   = AW'(r_cnt);

        case (r_state)
            ST_IDLE: begin
                w_err_nxt = 1'b0;
                w_ovf_nxt = 1'b0;
                if (w_in_xfer) begin
                    case (i_in_type)
                        SNAPSHOT_FLIT_TYPE_SINGLE: begin
                            w_wr_en     = 1'b1;
                            w_wr_addr   = '0;
                            w_cnt_nxt   = ONE_CNT;
                            w_state_nxt = ST_HDR;
                        end
                        SNAPSHOT_FLIT_TYPE_FIRST: begin
                            w_wr_en     = 1'b1;
                            w_wr_addr   = '0;
                            w_cnt_nxt   = ONE_CNT;
                            w_state_nxt = ST_COLLECT;
                        end
                        SNAPSHOT_FLIT_TYPE_NONE: begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_HDR;
                        end
                        default: begin
                            w_err_inc = 1'b1;
                        end
                    endcase
                end
            end
            ST_COLLECT: begin
                if (w_in_xfer) begin
                    case (i_in_type)
                        SNAPSHOT_FLIT_TYPE_MIDDLE,
                        SNAPSHOT_FLIT_TYPE_LAST: begin
                            // Words past MAX_ARGS are discarded but flagged
                            if (r_cnt < MAX_CNT) begin
                                w_wr_en   = 1'b1;
                                w_cnt_nxt = r_cnt + ONE_CNT;
                            end else begin
                                w_ovf_nxt = 1'b1;
                            end
                            if (i_in_type == SNAPSHOT_FLIT_TYPE_LAST) begin
                                w_state_nxt = ST_HDR;
                            end
                        end
                        default: begin
                            // Unexpected type closes the partial packet
                            w_err_nxt   = 1'b1;
                            w_err_inc   = 1'b1;
                            w_state_nxt = ST_HDR;
                        end
                    endcase
                end
            end
            ST_HDR: begin
                if (w_out_xfer) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_EMIT_HI;
                    end
                end
            end
            ST_EMIT_HI: begin
                if (w_out_xfer) begin
                    w_state_nxt = ST_EMIT_LO;
                end
            end
            ST_EMIT_LO: begin
                if (w_out_xfer) begin
                    if (w_last_arg) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + ONE_CNT;
                        w_state_nxt = ST_EMIT_HI;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read at the next emit pointer so the output word can be registered
    assign w_rd_addr = AW'(w_idx_nxt);

    // Output values for the coming cycle, decoded from next-state values
    always_comb begin
        w_in_rdy_nxt    = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_COLLECT);
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        w_out_data_nxt  = '0;
        case (w_state_nxt)
            ST_HDR: begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = pack_hdr(w_err_nxt, w_ovf_nxt, w_cnt_nxt);
                w_out_last_nxt  = (w_cnt_nxt == '0);
            end
            ST_EMIT_HI: begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = w_rd_data[FLIT_W-1:OUT_W];
            end
            ST_EMIT_LO: begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = w_rd_data[OUT_W-1:0];
                w_out_last_nxt  = (w_idx_nxt == (w_cnt_nxt - ONE_CNT));
            end
            default: begin
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_err_cnt   <= '0;
            r_in_rdy    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_err       <= w_err_nxt;
            r_ovf       <= w_ovf_nxt;
            r_in_rdy    <= w_in_rdy_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_data  <= w_out_data_nxt;
            if (w_err_inc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign o_in_rdy    = r_in_rdy;
    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_out_data  = r_out_data;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_stack_flit_receiver.sv
// Purpose: directed self-checking bench for stack_flit_receiver: a per-cycle
//          vector table plus hand-written overflow, stall, saturation and
//          mid-packet reset sequences.
module tb_stack_flit_receiver;
    import stack_flit_receiver_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_type = '0;
    logic        in_valid = 1'b0;
    logic        in_rdy;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  err_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    stack_flit_receiver #(.MAX_ARGS(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_data   (in_data),
        .i_in_type   (in_type),
        .i_in_valid  (in_valid),
        .o_in_rdy    (in_rdy),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_err_cnt   (err_cnt)
    );

    typedef struct {
        logic        v;
        logic [2:0]  t;
        logic [31:0] d;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [15:0] e_data;
        logic        e_last;
        logic [7:0]  e_ec;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] t, input logic [31:0] d,
                                input logic ordy, input logic e_rdy, input logic e_ov,
                                input logic [15:0] e_data, input logic e_last,
                                input logic [7:0] e_ec);
        vec_t r;
        r.v = v; r.t = t; r.d = d; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_data = e_data; r.e_last = e_last; r.e_ec = e_ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a flit until accepted, bounded
    task automatic send_flit(input logic [2:0] t, input logic [31:0] d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        for (int c = 0; c < 20 && !done; c++) begin
            if (in_rdy) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        in_type  = SNAPSHOT_FLIT_TYPE_NONE;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    // Expected packet: header then hi/lo halves of each stored argument
    function automatic void build_pkt(input logic [15:0] hdr, input logic [31:0] args[$],
                                      output logic [15:0] w[$]);
        w = {};
        w.push_back(hdr);
        foreach (args[i]) begin
            w.push_back(args[i][31:16]);
            w.push_back(args[i][15:0]);
        end
    endfunction

    // Drain one packet, optionally with out_ready stalls; checks every sample
    task automatic expect_pkt(input logic [15:0] w[$], input bit stall);
        chk("hdr_latency", 32'(out_valid), 32'd1);
        for (int k = 0; k < w.size(); k++) begin
            bit took;
            took = 1'b0;
            for (int c = 0; c < 40 && !took; c++) begin
                if (stall) out_ready = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                else       out_ready = 1'b1;
                if (out_valid) begin
                    chk($sformatf("word%0d", k), 32'(out_data), 32'(w[k]));
                    chk($sformatf("last%0d", k), 32'(out_last), 32'(k == w.size() - 1));
                    took = out_ready;
                end
                step();
            end
            if (!took) chk("word_timeout", 32'(took), 32'd1);
        end
        out_ready = 1'b0;
        chk("ov_after_pkt", 32'(out_valid), 32'd0);
        chk("rdy_after_pkt", 32'(in_rdy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[19];
        logic [31:0] args[$];
        logic [15:0] w[$];

        tbl[0]  = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        0, 1, 0, 16'h0000, 0, 8'd0);
        tbl[1]  = mk(1, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        0, 1, 0, 16'h0000, 0, 8'd0);
        tbl[2]  = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        1, 0, 1, 16'h0000, 1, 8'd0);
        tbl[3]  = mk(1, SNAPSHOT_FLIT_TYPE_SINGLE, 32'hDEADBEEF, 0, 1, 0, 16'h0000, 0, 8'd0);
        tbl[4]  = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        1, 0, 1, 16'h0001, 0, 8'd0);
        tbl[5]  = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        1, 0, 1, 16'hDEAD, 0, 8'd0);
        tbl[6]  = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        1, 0, 1, 16'hBEEF, 1, 8'd0);
        tbl[7]  = mk(1, SNAPSHOT_FLIT_TYPE_MIDDLE, 32'h55,       0, 1, 0, 16'h0000, 0, 8'd0);
        tbl[8]  = mk(1, SNAPSHOT_FLIT_TYPE_FIRST,  32'h11112222, 0, 1, 0, 16'h0000, 0, 8'd1);
        tbl[9]  = mk(1, SNAPSHOT_FLIT_TYPE_SINGLE, 32'h33334444, 0, 1, 0, 16'h0000, 0, 8'd1);
        tbl[10] = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        0, 0, 1, 16'h8001, 0, 8'd2);
        tbl[11] = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        1, 0, 1, 16'h8001, 0, 8'd2);
        tbl[12] = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        1, 0, 1, 16'h1111, 0, 8'd2);
        tbl[13] = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        1, 0, 1, 16'h2222, 1, 8'd2);
        tbl[14] = mk(1, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        0, 1, 0, 16'h0000, 0, 8'd2);
        tbl[15] = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        1, 0, 1, 16'h0000, 1, 8'd2);
        tbl[16] = mk(1, 3'd7,                      32'h0,        0, 1, 0, 16'h0000, 0, 8'd2);
        tbl[17] = mk(0, SNAPSHOT_FLIT_TYPE_SINGLE, 32'hAAAA5555, 0, 1, 0, 16'h0000, 0, 8'd3);
        tbl[18] = mk(0, SNAPSHOT_FLIT_TYPE_NONE,   32'h0,        0, 1, 0, 16'h0000, 0, 8'd3);

        // Reset values
        rst_n = 1'b0;
        step();
        step();
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // Per-cycle table: expected outputs are those seen before the edge
        for (int i = 0; i < 19; i++) begin
            in_valid  = tbl[i].v;
            in_type   = tbl[i].t;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            chk($sformatf("v%0d_in_rdy", i), 32'(in_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].e_ec));
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_data));
                chk($sformatf("v%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_last));
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // FIRST/MIDDLE/LAST with downstream stalls
        send_flit(SNAPSHOT_FLIT_TYPE_FIRST,  32'd1);
        send_flit(SNAPSHOT_FLIT_TYPE_MIDDLE, 32'd2);
        send_flit(SNAPSHOT_FLIT_TYPE_LAST,   32'd3);
        args = {32'd1, 32'd2, 32'd3};
        build_pkt(16'h0003, args, w);
        expect_pkt(w, 1'b1);

        // Overflow: 18 arguments offered, first 16 kept, ovf reported
        args = {};
        send_flit(SNAPSHOT_FLIT_TYPE_FIRST, {16'h1000, 16'h2000});
        args.push_back({16'h1000, 16'h2000});
        for (int i = 1; i <= 16; i++) begin
            send_flit(SNAPSHOT_FLIT_TYPE_MIDDLE, {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
            if (i < 16) args.push_back({16'h1000 + 16'(i), 16'h2000 + 16'(i)});
        end
        send_flit(SNAPSHOT_FLIT_TYPE_LAST, 32'hFFFF_FFFF);
        build_pkt(16'h4010, args, w);
        expect_pkt(w, 1'b0);
        chk("ovf_err_cnt", 32'(err_cnt), 32'd3);

        // Back-to-back: next snapshot accepted right after the last word
        send_flit(SNAPSHOT_FLIT_TYPE_SINGLE, 32'h0123_4567);
        args = {32'h0123_4567};
        build_pkt(16'h0001, args, w);
        expect_pkt(w, 1'b1);

        // Reset during EMIT_LO of a 4-argument packet
        send_flit(SNAPSHOT_FLIT_TYPE_FIRST,  32'hA0A0_0000);
        send_flit(SNAPSHOT_FLIT_TYPE_MIDDLE, 32'hA1A1_0001);
        send_flit(SNAPSHOT_FLIT_TYPE_MIDDLE, 32'hA2A2_0002);
        send_flit(SNAPSHOT_FLIT_TYPE_LAST,   32'hA3A3_0003);
        out_ready = 1'b1;
        chk("rp_hdr", 32'(out_data), 32'h0004);
        step();
        chk("rp_hi0", 32'(out_data), 32'hA0A0);
        step();
        chk("rp_lo0", 32'(out_data), 32'h0000);
        step();
        chk("rp_hi1", 32'(out_data), 32'hA1A1);
        step();
        out_ready = 1'b0;
        chk("rp_lo1", 32'(out_data), 32'h0001);
        chk("rp_lo1_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rp_ov_in_rst", 32'(out_valid), 32'd0);
        chk("rp_rdy_in_rst", 32'(in_rdy), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rp_rdy_after", 32'(in_rdy), 32'd1);
        chk("rp_ov_after", 32'(out_valid), 32'd0);
        chk("rp_err_cnt", 32'(err_cnt), 32'd0);
        send_flit(SNAPSHOT_FLIT_TYPE_SINGLE, 32'hCAFE_F00D);
        args = {32'hCAFE_F00D};
        build_pkt(16'h0001, args, w);
        expect_pkt(w, 1'b0);

        // err_cnt saturation
        for (int i = 0; i < 260; i++) begin
            send_flit(SNAPSHOT_FLIT_TYPE_LAST, 32'(i));
        end
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);
        chk("sat_no_output", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stack_flit_receiver.md
# stack_flit_receiver

Consumer end of the stack-argument snapshot flit stream produced by the system-diagnosis stack module. It accepts FIRST/MIDDLE/LAST/SINGLE/NONE typed 32-bit argument flits over a valid/ready handshake and checks framing. It buffers one snapshot, then serializes it as a header word plus 16-bit halves onto the 16-bit debug-interconnect side toward the diagnosis packetizer.

## Interface
- MAX_ARGS, 16, argument buffer depth; must equal the diagnosis stack-args maximum; legal range 1..63.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- in_data  in  32  argument word from the stack module.
- in_type  in  3  flit type; sampled only on a transfer.
- in_valid  in  1  producer has a flit.
- in_rdy  out  1  receiver accepts; transfer = in_valid && in_rdy.
- out_data  out  16  debug word.
- out_last  out  1  marks the final word of a packet.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts; transfer = out_valid && out_ready.
- err_cnt  out  8  saturating framing-error count.

## Operation
- Flit types: NONE=3'd0, FIRST=3'd1, MIDDLE=3'd2, LAST=3'd3, SINGLE=3'd4. Values 5..7 are treated as framing errors.
- A NONE transfer is a valid zero-argument snapshot. The type seen while the producer's handshake is not complete is ignored.
- Registers:
  - cnt, 6 bits: arguments stored.
  - idx, 6 bits: emit pointer.
  - err: framing-error bit.
  - ovf: overflow bit.
  - buf: MAX_ARGS x 32.
- FSM states: IDLE, COLLECT, HDR, EMIT_HI, EMIT_LO.
- IDLE: in_rdy=1; err=0 and ovf=0 on entry. On a transfer:
  - SINGLE: buf[0]=data, cnt=1, go to HDR.
  - FIRST: buf[0]=data, cnt=1, go to COLLECT.
  - NONE: cnt=0, go to HDR.
  - MIDDLE, LAST or illegal type: flit dropped, err_cnt++, stay in IDLE.
- COLLECT: in_rdy=1.
  - MIDDLE: if cnt<MAX_ARGS, buf[cnt]=data and cnt++; otherwise the word is dropped and ovf=1.
  - LAST: stored by the same rule, then go to HDR.
  - FIRST, SINGLE, NONE or illegal type: flit dropped, err=1, err_cnt++, go to HDR. The partial packet is closed.
- HDR: in_rdy=0, out_valid=1.
  - out_data = {err, ovf, 8'b0, cnt[5:0]}.
  - out_last = (cnt==0).
  - On transfer: if cnt==0 go to IDLE; otherwise idx=0 and go to EMIT_HI.
- EMIT_HI: out_data=buf[idx][31:16], out_last=0; on transfer go to EMIT_LO.
- EMIT_LO: out_data=buf[idx][15:0], out_last=(idx==cnt-1).
  - On transfer: if last, go to IDLE; otherwise idx++ and go to EMIT_HI.
- err_cnt saturates at 255 and is cleared only by reset.
- An n-argument packet is 1+2n words. n is clamped to MAX_ARGS; ovf reports any discarded words.

## Timing
- Reset values:
  - in_rdy=0 while rst_n=0, and 1 in the first cycle after release (state IDLE).
  - out_valid=0, out_last=0, out_data=0, err_cnt=0, cnt=0, idx=0.
  - buf is not reset.
- Reset asserted mid-packet aborts the packet immediately. No partial output follows.
- Latency: the header is valid in the cycle after the closing LAST/SINGLE/NONE transfer. With out_ready held high, one word is output per cycle.
- out_data and out_last stay stable while out_valid=1 and out_ready=0.
- in_rdy is a registered function of state only. It never depends on in_valid or out_ready combinationally.
- No input is accepted from HDR until the return to IDLE. The producer stalls during that time.
- Back-to-back snapshots: IDLE accepts a flit in the cycle following the final output transfer.

## Structure
- The shared diagnosis configuration header holds:
  - the SNAPSHOT_FLIT_TYPE_* constants;
  - header bit positions (ERR=15, OVF=14, CNT=5:0);
  - the stack-args maximum that MAX_ARGS defaults to.
- One sub-module, stack_arg_buf: MAX_ARGS x 32 register file with one synchronous write port and one asynchronous read port, indexed by idx.
- The FSM, counters and output mux live in stack_flit_receiver.

## Test plan
- NONE transfer -> single word 16'h0000 with out_last=1; in_rdy returns to 1 after it.
- SINGLE 32'hDEADBEEF -> words 16'h0001, 16'hDEAD, 16'hBEEF; last asserted on 16'hBEEF.
- FIRST 1, MIDDLE 2, LAST 3 with random out_ready stalls -> 0x0003, 0000,0001, 0000,0002, 0000,0003; data stable during stalls.
- FIRST, then 16 MIDDLE, then LAST (MAX_ARGS=16) -> header 0x4010; 32 data words with the first 16 arguments; ovf set.
- Frame and count errors:
  - MIDDLE in IDLE -> no output, err_cnt=1.
  - FIRST then SINGLE -> header 0x8001, one argument emitted, err_cnt=2.
- Reset asserted during EMIT_LO of a 4-argument packet -> out_valid=0 next cycle; a following SINGLE produces a clean 3-word packet.
